// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined ALU with valid/ready handshake and saturating op counter
module alu_pipe #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic [CNT_W-1:0] ops_done
);
   localparam int SH_W = $clog2(WIDTH);

   typedef enum logic [2:0] {
      OP_ADDU = 3'd0,
      OP_SUBU = 3'd1,
      OP_AND  = 3'd2,
      OP_XOR  = 3'd3,
      OP_OR   = 3'd4,
      OP_SLL  = 3'd5,
      OP_SRL  = 3'd6,
      OP_SLT  = 3'd7
   } opCode;

   logic             s1Valid;
   logic [2:0]       s1Op;
   logic [WIDTH-1:0] s1A;
   logic [WIDTH-1:0] s1B;
   logic [WIDTH:0]   s1Sum;
   logic             s2Valid;
   logic             s2Adv;
   logic [WIDTH:0]   sumNext;
   logic [WIDTH-1:0] resNext;
   logic             carryNext;

   assign s2Adv     = !s2Valid || out_ready;
   assign in_ready  = !s1Valid || s2Adv;
   assign out_valid = s2Valid;

   // The extra MSB of the difference is the unsigned borrow (a < b).
   always_comb begin
      sumNext = {1'b0, a} + {1'b0, b};
      if (op == OP_SUBU) sumNext = {1'b0, a} - {1'b0, b};
   end

   always_comb begin
      resNext   = '0;
      carryNext = 1'b0;
      case (s1Op)
         OP_ADDU, OP_SUBU: begin
            resNext   = s1Sum[WIDTH-1:0];
            carryNext = s1Sum[WIDTH];
         end
         OP_AND:  resNext = s1A & s1B;
         OP_XOR:  resNext = s1A ^ s1B;
         OP_OR:   resNext = s1A | s1B;
         OP_SLL:  resNext = s1A << s1B[SH_W-1:0];
         OP_SRL:  resNext = s1A >> s1B[SH_W-1:0];
         OP_SLT:  resNext = {{(WIDTH-1){1'b0}}, ($signed(s1A) < $signed(s1B))};
         default: resNext = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1Valid  <= 1'b0;
         s1Op     <= '0;
         s1A      <= '0;
         s1B      <= '0;
         s1Sum    <= '0;
         s2Valid  <= 1'b0;
         result   <= '0;
         zero     <= 1'b0;
         carry    <= 1'b0;
         ops_done <= '0;
      end else begin
         if (in_ready) begin
            s1Valid <= in_valid;
            s1Op    <= op;
            s1A     <= a;
            s1B     <= b;
            s1Sum   <= sumNext;
         end
         if (s2Adv) begin
            s2Valid <= s1Valid;
            result  <= resNext;
            zero    <= (resNext == '0);
            carry   <= carryNext;
         end
         if (out_valid && out_ready && (ops_done != '1))
            ops_done <= ops_done + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe: queue model plus directed literal vectors
module tb_alu_pipe;
   typedef struct {
      logic [7:0] r;
      logic       z;
      logic       c;
      int         acc;
   } item_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       inValid = 1'b0;
   logic       outReady = 1'b1;
   logic [2:0] op = 3'd0;
   logic [7:0] a = 8'd0;
   logic [7:0] b = 8'd0;

   logic        inReady, outValid, zero, carry;
   logic [7:0]  result;
   logic [15:0] opsDone;
   logic        satInReady, satOutValid, satZero, satCarry;
   logic [7:0]  satResult;
   logic [1:0]  satOps;

   int nChecks = 0;
   int nErrors = 0;

   item_t      q[$];
   logic [7:0] seen[$];
   int         modelCnt = 0;
   int         edges = 0;
   logic       armed = 1'b0;
   logic       expReady, expValid;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady), .op(op),
      .a(a), .b(b), .out_valid(outValid), .out_ready(outReady), .result(result),
      .zero(zero), .carry(carry), .ops_done(opsDone)
   );

   alu_pipe #(.WIDTH(8), .CNT_W(2)) dutSat (
      .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(satInReady), .op(op),
      .a(a), .b(b), .out_valid(satOutValid), .out_ready(outReady), .result(satResult),
      .zero(satZero), .carry(satCarry), .ops_done(satOps)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic item_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      item_t      it;
      logic [8:0] s;
      it.c = 1'b0;
      it.acc = 0;
      case (o)
         3'd0: begin s = {1'b0, x} + {1'b0, y}; it.r = s[7:0]; it.c = s[8]; end
         3'd1: begin it.r = x - y; it.c = (x < y); end
         3'd2: it.r = x & y;
         3'd3: it.r = x ^ y;
         3'd4: it.r = x | y;
         3'd5: it.r = x << y[2:0];
         3'd6: it.r = x >> y[2:0];
         default: it.r = ($signed(x) < $signed(y)) ? 8'd1 : 8'd0;
      endcase
      it.z = (it.r == 8'd0);
      return it;
   endfunction

   // Model: at most two ops in flight; the oldest is visible one edge after its capture edge.
   always @(negedge clk) begin
      item_t it;
      if (armed) begin
         expReady = (q.size() < 2) || outReady;
         expValid = (q.size() > 0) && ((edges - q[0].acc) >= 1);
         check("in_ready", 32'(inReady), 32'(expReady));
         check("out_valid", 32'(outValid), 32'(expValid));
         check("sat_out_valid", 32'(satOutValid), 32'(expValid));
         check("ops_done", 32'(opsDone), 32'(modelCnt));
         check("sat_ops_done", 32'(satOps), (modelCnt > 3) ? 32'd3 : 32'(modelCnt));
         if (expValid) begin
            check("result", 32'(result), 32'(q[0].r));
            check("zero", 32'(zero), 32'(q[0].z));
            check("carry", 32'(carry), 32'(q[0].c));
            check("sat_result", 32'(satResult), 32'(q[0].r));
         end
      end
      if (reset) begin
         q.delete();
         modelCnt = 0;
         armed = 1'b1;
      end else if (armed) begin
         if (outValid && outReady) seen.push_back(result);
         if (expValid && outReady) begin
            void'(q.pop_front());
            modelCnt++;
         end
         if (inValid && expReady) begin
            it = model(op, a, b);
            it.acc = edges + 1;
            q.push_back(it);
         end
      end
      edges++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic doOp(input string nm, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] er, input logic ez, input logic ec);
      int lat;
      outReady = 1'b1;
      op = o; a = x; b = y; inValid = 1'b1;
      tick;
      inValid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!outValid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check({nm, "_latency"}, 32'(lat), 32'd2);
      check({nm, "_result"}, 32'(result), 32'(er));
      check({nm, "_zero"}, 32'(zero), 32'(ez));
      check({nm, "_carry"}, 32'(carry), 32'(ec));
      tick;
   endtask

   logic [2:0] bpOp[4];
   logic [7:0] bpA[4];
   logic [7:0] bpB[4];
   logic [7:0] bpExp[4];

   initial begin
      int acc, guard, holdCnt;
      logic r, dropped;
      bpOp  = '{3'd0, 3'd1, 3'd3, 3'd4};
      bpA   = '{8'h10, 8'h10, 8'hAA, 8'h01};
      bpB   = '{8'h01, 8'h01, 8'h55, 8'h02};
      bpExp = '{8'h11, 8'h0F, 8'hFF, 8'h03};

      reset = 1'b1;
      repeat (2) tick;
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 32'(inReady), 32'd1);
      check("rst_out_valid", 32'(outValid), 32'd0);
      check("rst_ops_done", 32'(opsDone), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_zero", 32'(zero), 32'd0);
      check("rst_carry", 32'(carry), 32'd0);
      tick;

      doOp("addu_carry", 3'd0, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1);
      doOp("addu_wrap0", 3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
      doOp("subu_eq",    3'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0);
      doOp("subu_borrow",3'd1, 8'h03, 8'h04, 8'hFF, 1'b0, 1'b1);
      doOp("and",        3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
      doOp("xor",        3'd3, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0);
      doOp("or",         3'd4, 8'h0A, 8'h50, 8'h5A, 1'b0, 1'b0);
      doOp("sll",        3'd5, 8'h81, 8'h09, 8'h02, 1'b0, 1'b0);
      doOp("srl",        3'd6, 8'h80, 8'h07, 8'h01, 1'b0, 1'b0);
      doOp("slt_neg",    3'd7, 8'hFF, 8'h01, 8'h01, 1'b0, 1'b0);
      doOp("slt_pos",    3'd7, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0);

      // Backpressure: four ops into a stalled pipe, then release.
      reset = 1'b1;
      tick;
      reset = 1'b0;
      seen.delete();
      outReady = 1'b0;
      inValid = 1'b1;
      acc = 0; guard = 0; holdCnt = 0; dropped = 1'b0;
      while (acc < 4 && guard < 30) begin
         op = bpOp[acc]; a = bpA[acc]; b = bpB[acc];
         @(negedge clk);
         r = inReady;
         if (!r && !dropped) begin
            dropped = 1'b1;
            check("bp_accepted_at_drop", 32'(acc), 32'd2);
            check("bp_hold_valid", 32'(outValid), 32'd1);
            check("bp_hold_result", 32'(result), 32'h11);
         end
         @(posedge clk);
         #1;
         if (r) acc++;
         guard++;
         if (dropped) begin
            holdCnt++;
            if (holdCnt == 3) outReady = 1'b1;
         end
      end
      inValid = 1'b0;
      check("bp_all_accepted", 32'(acc), 32'd4);
      guard = 0;
      while (seen.size() < 4 && guard < 20) begin
         tick;
         guard++;
      end
      check("bp_out_count", 32'(seen.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < seen.size()) check($sformatf("bp_order_%0d", i), 32'(seen[i]), 32'(bpExp[i]));
      @(negedge clk);
      check("bp_ops_done", 32'(opsDone), 32'd4);
      tick;

      // Reset with both stages full drops everything in flight.
      outReady = 1'b0;
      inValid = 1'b1;
      op = 3'd0; a = 8'h01; b = 8'h01;
      tick;
      a = 8'h02;
      tick;
      inValid = 1'b0;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      @(negedge clk);
      check("rstfull_out_valid", 32'(outValid), 32'd0);
      check("rstfull_ops_done", 32'(opsDone), 32'd0);
      check("rstfull_in_ready", 32'(inReady), 32'd1);
      tick;
      seen.delete();
      outReady = 1'b1;
      repeat (5) tick;
      check("rstfull_no_stale", 32'(seen.size()), 32'd0);

      // Five transfers: narrow counter saturates at 3.
      for (int i = 0; i < 5; i++) begin
         inValid = 1'b1;
         op = 3'd3; a = 8'(i); b = 8'h5A;
         tick;
      end
      inValid = 1'b0;
      repeat (4) tick;
      @(negedge clk);
      check("sat_wide_count", 32'(opsDone), 32'd5);
      check("sat_narrow_count", 32'(satOps), 32'd3);
      tick;

      // Mixed traffic with random backpressure, checked by the model each cycle.
      for (int i = 0; i < 80; i++) begin
         inValid = 1'($urandom_range(0, 1));
         outReady = ($urandom_range(0, 3) != 0);
         op = 3'($urandom_range(0, 7));
         a = 8'($urandom);
         b = 8'($urandom);
         tick;
      end
      inValid = 1'b0;
      outReady = 1'b1;
      repeat (5) tick;

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule
